// File: rtl/flash_prog_pkg.sv
// Shared types and constants for the boot-flash programming sequencer.
package flash_prog_pkg;

    localparam int unsigned ADDR_W = 19;

    typedef enum logic [2:0] {
        CMD_NONE  = 3'd0,
        CMD_PROG  = 3'd1,
        CMD_SECT  = 3'd2,
        CMD_CHIP  = 3'd3
    } cmd_e;

    typedef enum logic [3:0] {
        ST_IDLE       = 4'd0,
        ST_WAIT_GNT   = 4'd1,
        ST_W_SETUP    = 4'd2,
        ST_W_PULSE    = 4'd3,
        ST_W_HOLD     = 4'd4,
        ST_R_WAIT_GNT = 4'd5,
        ST_R_PULSE    = 4'd6,
        ST_R_GAP      = 4'd7,
        ST_DONE       = 4'd8
    } state_e;

    // Where a write step takes its address (and, for SEL_ADDR_DATA, its data)
    typedef enum logic [1:0] {
        SEL_5555      = 2'd0,
        SEL_2AAA      = 2'd1,
        SEL_ADDR      = 2'd2,
        SEL_ADDR_DATA = 2'd3
    } addr_sel_e;

    localparam logic [2:0] REG_ADDR_L = 3'd0;
    localparam logic [2:0] REG_ADDR_M = 3'd1;
    localparam logic [2:0] REG_ADDR_U = 3'd2;
    localparam logic [2:0] REG_DATA   = 3'd3;
    localparam logic [2:0] REG_CMD    = 3'd4;

    localparam int unsigned ST_BUSY   = 7;
    localparam int unsigned ST_DONE_B = 6;
    localparam int unsigned ST_TMO    = 5;
    localparam int unsigned ST_VFAIL  = 4;
    localparam int unsigned ST_IGN    = 3;

    localparam logic [ADDR_W-1:0] UNLOCK_A = 19'h05555;
    localparam logic [ADDR_W-1:0] UNLOCK_B = 19'h02AAA;

    localparam logic [7:0] BYTE_AA = 8'hAA;
    localparam logic [7:0] BYTE_55 = 8'h55;
    localparam logic [7:0] BYTE_A0 = 8'hA0;
    localparam logic [7:0] BYTE_80 = 8'h80;
    localparam logic [7:0] BYTE_30 = 8'h30;
    localparam logic [7:0] BYTE_10 = 8'h10;

    function automatic logic is_valid_cmd(input logic [7:0] code);
        return (code == 8'(CMD_PROG)) || (code == 8'(CMD_SECT)) || (code == 8'(CMD_CHIP));
    endfunction

endpackage

// File: rtl/flash_cmd_rom.sv
// Maps (command, step) to the JEDEC write sequence entry for that step.
module flash_cmd_rom
    import flash_prog_pkg::*;
(
    input  cmd_e        cmd,
    input  logic [2:0]  step,
    output addr_sel_e   addr_sel,
    output logic [7:0]  data,
    output logic        last
);

    always_comb begin
        addr_sel = SEL_5555;
        data     = BYTE_AA;
        last     = 1'b0;
        case (step)
            3'd0: begin
                addr_sel = SEL_5555;
                data     = BYTE_AA;
            end
            3'd1: begin
                addr_sel = SEL_2AAA;
                data     = BYTE_55;
            end
            3'd2: begin
                addr_sel = SEL_5555;
                data     = (cmd == CMD_PROG) ? BYTE_A0 : BYTE_80;
            end
            3'd3: begin
                if (cmd == CMD_PROG) begin
                    addr_sel = SEL_ADDR_DATA;
                    last     = 1'b1;
                end else begin
                    addr_sel = SEL_5555;
                    data     = BYTE_AA;
                end
            end
            3'd4: begin
                addr_sel = SEL_2AAA;
                data     = BYTE_55;
            end
            3'd5: begin
                last = 1'b1;
                if (cmd == CMD_SECT) begin
                    addr_sel = SEL_ADDR;
                    data     = BYTE_30;
                end else begin
                    addr_sel = SEL_5555;
                    data     = BYTE_10;
                end
            end
            default: last = 1'b1;
        endcase
    end

endmodule

// File: rtl/flash_prog_ctl.sv
// Boot-flash programming sequencer: register window, JEDEC write sequencing,
// DQ6 toggle polling with timeout, and program verify.
module flash_prog_ctl
    import flash_prog_pkg::*;
#(
    parameter int unsigned WE_CYCLES = 2,
    parameter int unsigned RD_CYCLES = 2,
    parameter int unsigned TIMEOUT_W = 20
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [2:0]        reg_sel,
    input  logic              reg_we,
    input  logic              reg_re,
    input  logic [7:0]        reg_wdata,
    output logic [7:0]        reg_rdata,
    output logic              flash_req,
    input  logic              flash_gnt,
    output logic [ADDR_W-1:0] f_addr,
    output logic [7:0]        f_dout,
    input  logic [7:0]        f_din,
    output logic              f_drive,
    output logic              f_ce,
    output logic              f_we,
    output logic              f_oe
);

    localparam int unsigned CNT_W = (WE_CYCLES > RD_CYCLES) ? $clog2(WE_CYCLES + 1)
                                                            : $clog2(RD_CYCLES + 1);

    state_e               state;
    cmd_e                 cmd;
    logic [2:0]           step;
    logic [CNT_W-1:0]     cnt;
    logic [TIMEOUT_W-1:0] poll_cnt;
    logic [TIMEOUT_W-1:0] poll_inc;
    logic [7:0]           addr_l;
    logic [7:0]           addr_m;
    logic [2:0]           addr_u;
    logic [7:0]           data_reg;
    logic [7:0]           rd_data;
    logic                 prev_dq6;
    logic [1:0]           nreads;
    logic                 busy;
    logic                 done;
    logic                 timeout;
    logic                 verify_fail;
    logic                 cmd_ign;

    logic [ADDR_W-1:0]    addr_full;
    addr_sel_e            rom_sel;
    logic [7:0]           rom_data;
    logic                 rom_last;
    logic [ADDR_W-1:0]    step_addr;
    logic [7:0]           step_dout;
    logic [7:0]           status;
    logic                 cmd_wr;
    logic                 cmd_ok;
    logic                 st_clr;

    flash_cmd_rom u_rom (
        .cmd      (cmd),
        .step     (step),
        .addr_sel (rom_sel),
        .data     (rom_data),
        .last     (rom_last)
    );

    assign addr_full = {addr_u, addr_m, addr_l};
    assign poll_inc  = poll_cnt + TIMEOUT_W'(1);
    assign cmd_wr    = reg_we && (reg_sel == REG_CMD);
    assign cmd_ok    = is_valid_cmd(reg_wdata);
    assign st_clr    = reg_re && (reg_sel == REG_CMD);

    // Address/data presented for the current write step
    always_comb begin
        step_addr = UNLOCK_A;
        step_dout = rom_data;
        case (rom_sel)
            SEL_5555:      step_addr = UNLOCK_A;
            SEL_2AAA:      step_addr = UNLOCK_B;
            SEL_ADDR:      step_addr = addr_full;
            SEL_ADDR_DATA: begin
                step_addr = addr_full;
                step_dout = data_reg;
            end
            default:       step_addr = UNLOCK_A;
        endcase
    end

    always_comb begin
        status              = '0;
        status[ST_BUSY]     = busy;
        status[ST_DONE_B]   = done;
        status[ST_TMO]      = timeout;
        status[ST_VFAIL]    = verify_fail;
        status[ST_IGN]      = cmd_ign;
        status[2:0]         = cmd;
    end

    always_comb begin
        reg_rdata = '0;
        case (reg_sel)
            REG_ADDR_L: reg_rdata = addr_l;
            REG_ADDR_M: reg_rdata = addr_m;
            REG_ADDR_U: reg_rdata = {5'b0, addr_u};
            REG_DATA:   reg_rdata = data_reg;
            REG_CMD:    reg_rdata = status;
            default:    reg_rdata = '0;
        endcase
    end

    // Sequencer, register window and sticky status; later status sets override the read-clear
    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= ST_IDLE;
            cmd         <= CMD_NONE;
            step        <= '0;
            cnt         <= '0;
            poll_cnt    <= '0;
            addr_l      <= '0;
            addr_m      <= '0;
            addr_u      <= '0;
            data_reg    <= 8'hFF;
            rd_data     <= '0;
            prev_dq6    <= 1'b0;
            nreads      <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            timeout     <= 1'b0;
            verify_fail <= 1'b0;
            cmd_ign     <= 1'b0;
            flash_req   <= 1'b0;
            f_addr      <= '0;
            f_dout      <= '0;
            f_drive     <= 1'b0;
            f_ce        <= 1'b0;
            f_we        <= 1'b0;
            f_oe        <= 1'b0;
        end else begin
            f_drive <= 1'b0;
            f_ce    <= 1'b0;
            f_we    <= 1'b0;
            f_oe    <= 1'b0;

            if (st_clr) begin
                done        <= 1'b0;
                timeout     <= 1'b0;
                verify_fail <= 1'b0;
                cmd_ign     <= 1'b0;
            end

            if (reg_we && !busy) begin
                case (reg_sel)
                    REG_ADDR_L: addr_l   <= reg_wdata;
                    REG_ADDR_M: addr_m   <= reg_wdata;
                    REG_ADDR_U: addr_u   <= reg_wdata[2:0];
                    REG_DATA:   data_reg <= reg_wdata;
                    default:    ;
                endcase
            end

            if (cmd_wr && (busy || !cmd_ok)) begin
                cmd_ign <= 1'b1;
            end

            case (state)
                ST_IDLE: begin
                    if (cmd_wr && cmd_ok) begin
                        cmd       <= cmd_e'(reg_wdata[2:0]);
                        step      <= '0;
                        poll_cnt  <= '0;
                        nreads    <= '0;
                        busy      <= 1'b1;
                        flash_req <= 1'b1;
                        state     <= ST_WAIT_GNT;
                    end
                end
                ST_WAIT_GNT: begin
                    if (flash_gnt) begin
                        f_addr  <= step_addr;
                        f_dout  <= step_dout;
                        f_ce    <= 1'b1;
                        f_drive <= 1'b1;
                        state   <= ST_W_SETUP;
                    end
                end
                ST_W_SETUP: begin
                    cnt     <= '0;
                    f_ce    <= 1'b1;
                    f_drive <= 1'b1;
                    f_we    <= 1'b1;
                    state   <= ST_W_PULSE;
                end
                ST_W_PULSE: begin
                    f_ce    <= 1'b1;
                    f_drive <= 1'b1;
                    if (cnt == CNT_W'(WE_CYCLES - 1)) begin
                        state <= ST_W_HOLD;
                    end else begin
                        cnt  <= cnt + CNT_W'(1);
                        f_we <= 1'b1;
                    end
                end
                ST_W_HOLD: begin
                    if (rom_last) begin
                        state <= ST_R_WAIT_GNT;
                    end else begin
                        step  <= step + 3'd1;
                        state <= ST_WAIT_GNT;
                    end
                end
                ST_R_WAIT_GNT: begin
                    if (flash_gnt) begin
                        cnt    <= '0;
                        f_addr <= addr_full;
                        f_ce   <= 1'b1;
                        f_oe   <= 1'b1;
                        state  <= ST_R_PULSE;
                    end
                end
                ST_R_PULSE: begin
                    if (cnt == CNT_W'(RD_CYCLES - 1)) begin
                        prev_dq6 <= rd_data[6];
                        rd_data  <= f_din;
                        if (nreads != 2'd2) begin
                            nreads <= nreads + 2'd1;
                        end
                        state <= ST_R_GAP;
                    end else begin
                        cnt  <= cnt + CNT_W'(1);
                        f_ce <= 1'b1;
                        f_oe <= 1'b1;
                    end
                end
                ST_R_GAP: begin
                    if ((nreads == 2'd2) && (rd_data[6] == prev_dq6)) begin
                        if ((cmd == CMD_PROG) && (rd_data != data_reg)) begin
                            verify_fail <= 1'b1;
                        end
                        flash_req <= 1'b0;
                        state     <= ST_DONE;
                    end else if (&poll_inc) begin
                        timeout   <= 1'b1;
                        flash_req <= 1'b0;
                        state     <= ST_DONE;
                    end else begin
                        poll_cnt <= poll_inc;
                        state    <= ST_R_WAIT_GNT;
                    end
                end
                ST_DONE: begin
                    busy      <= 1'b0;
                    done      <= 1'b1;
                    flash_req <= 1'b0;
                    state     <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_flash_prog_ctl.sv
// Directed bench for flash_prog_ctl with a DQ6-toggling flash model.
module tb_flash_prog_ctl;

    localparam int unsigned WE_CYCLES = 2;
    localparam int unsigned RD_CYCLES = 2;
    localparam int unsigned TIMEOUT_W = 4;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [2:0]  reg_sel = 3'd4;
    logic        reg_we = 1'b0;
    logic        reg_re = 1'b0;
    logic [7:0]  reg_wdata = 8'h00;
    logic [7:0]  reg_rdata;
    logic        flash_req;
    logic        flash_gnt = 1'b1;
    logic [18:0] f_addr;
    logic [7:0]  f_dout;
    logic [7:0]  f_din;
    logic        f_drive;
    logic        f_ce;
    logic        f_we;
    logic        f_oe;

    int n_checks = 0;
    int n_errors = 0;

    // Flash model and bus monitor state
    int          rd_cnt = 0;
    int          rd_base = 0;
    int          rd_rel;
    int          tog_n = 0;
    bit          tog_forever = 1'b0;
    logic [7:0]  final_val = 8'h00;
    int          we_len = 0;
    int          oe_len = 0;
    int          bad_pulse = 0;
    int          we_nognt = 0;
    int          we_bad = 0;
    logic [18:0] wr_addr_q[$];
    logic [7:0]  wr_data_q[$];
    int          wr_base = 0;

    flash_prog_ctl #(
        .WE_CYCLES (WE_CYCLES),
        .RD_CYCLES (RD_CYCLES),
        .TIMEOUT_W (TIMEOUT_W)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .reg_sel   (reg_sel),
        .reg_we    (reg_we),
        .reg_re    (reg_re),
        .reg_wdata (reg_wdata),
        .reg_rdata (reg_rdata),
        .flash_req (flash_req),
        .flash_gnt (flash_gnt),
        .f_addr    (f_addr),
        .f_dout    (f_dout),
        .f_din     (f_din),
        .f_drive   (f_drive),
        .f_ce      (f_ce),
        .f_we      (f_we),
        .f_oe      (f_oe)
    );

    always #5 clock = ~clock;

    always_comb begin
        rd_rel = rd_cnt - rd_base;
        if (tog_forever || (rd_rel < tog_n)) begin
            f_din = rd_rel[0] ? 8'h00 : 8'h40;
        end else begin
            f_din = final_val;
        end
    end

    always @(negedge clock) begin
        if (f_we) begin
            we_len = we_len + 1;
            if (!flash_gnt) we_nognt = we_nognt + 1;
            if (!(f_ce && f_drive)) we_bad = we_bad + 1;
        end else if (we_len != 0) begin
            if (we_len != int'(WE_CYCLES)) bad_pulse = bad_pulse + 1;
            wr_addr_q.push_back(f_addr);
            wr_data_q.push_back(f_dout);
            we_len = 0;
        end
        if (f_oe) begin
            oe_len = oe_len + 1;
        end else if (oe_len != 0) begin
            rd_cnt = rd_cnt + 1;
            oe_len = 0;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks = n_checks + 1;
        if (got !== exp) begin
            n_errors = n_errors + 1;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic reg_write(input logic [2:0] sel, input logic [7:0] val);
        @(negedge clock);
        reg_sel   = sel;
        reg_wdata = val;
        reg_we    = 1'b1;
        @(negedge clock);
        reg_we    = 1'b0;
        reg_sel   = 3'd4;
        #1;
    endtask

    task automatic reg_peek(input logic [2:0] sel, output logic [7:0] val);
        reg_sel = sel;
        #1;
        val = reg_rdata;
        reg_sel = 3'd4;
        #1;
    endtask

    task automatic status_read(output logic [7:0] val);
        @(negedge clock);
        reg_sel = 3'd4;
        reg_re  = 1'b1;
        #1;
        val = reg_rdata;
        @(negedge clock);
        reg_re = 1'b0;
        #1;
    endtask

    task automatic wait_done(input string tag, input int max_cyc);
        bit ok = 1'b0;
        for (int i = 0; i < max_cyc; i++) begin
            @(negedge clock);
            #1;
            if (!reg_rdata[7] && reg_rdata[6]) begin
                ok = 1'b1;
                break;
            end
        end
        check(tag, 32'(ok), 32'd1);
    endtask

    task automatic wait_writes(input string tag, input int n, input bit need_we, input int max_cyc);
        bit ok = 1'b0;
        for (int i = 0; i < max_cyc; i++) begin
            @(negedge clock);
            #1;
            if ((wr_addr_q.size() - wr_base == n) && (!need_we || f_we)) begin
                ok = 1'b1;
                break;
            end
        end
        check(tag, 32'(ok), 32'd1);
    endtask

    task automatic check_wr(input int idx, input logic [18:0] ea, input logic [7:0] ed);
        if (wr_base + idx < wr_addr_q.size()) begin
            check($sformatf("wr%0d_addr", idx), 32'(wr_addr_q[wr_base + idx]), 32'(ea));
            check($sformatf("wr%0d_data", idx), 32'(wr_data_q[wr_base + idx]), 32'(ed));
        end else begin
            check($sformatf("wr%0d_missing", idx), 32'(wr_addr_q.size() - wr_base), 32'(idx + 1));
        end
    endtask

    task automatic start_op(input int tn, input bit forever_t, input logic [7:0] fv);
        wr_base     = wr_addr_q.size();
        rd_base     = rd_cnt;
        tog_n       = tn;
        tog_forever = forever_t;
        final_val   = fv;
    endtask

    logic [7:0] v;

    initial begin
        repeat (3) @(negedge clock);
        reset = 1'b0;
        #1;

        // Reset state
        reg_peek(3'd4, v); check("rst_status", 32'(v), 32'h00);
        reg_peek(3'd0, v); check("rst_addr_l", 32'(v), 32'h00);
        reg_peek(3'd3, v); check("rst_data", 32'(v), 32'hFF);
        check("rst_req", 32'(flash_req), 32'd0);
        check("rst_strobes", 32'({f_ce, f_we, f_oe, f_drive}), 32'd0);
        check("rst_faddr", 32'(f_addr), 32'd0);

        // Byte program 0x01234 <- 0x5A, continuous grant
        reg_write(3'd0, 8'h34);
        reg_write(3'd1, 8'h12);
        reg_write(3'd2, 8'hF8);
        reg_write(3'd3, 8'h5A);
        reg_peek(3'd1, v); check("addr_m_rb", 32'(v), 32'h12);
        reg_peek(3'd2, v); check("addr_u_rb", 32'(v), 32'h00);
        start_op(4, 1'b0, 8'h5A);
        reg_write(3'd4, 8'h01);
        check("prog_busy", 32'(reg_rdata), 32'h81);
        check("prog_req", 32'(flash_req), 32'd1);
        wait_done("prog_done_wait", 400);
        check("prog_status", 32'(reg_rdata), 32'h41);
        check("prog_nwr", 32'(wr_addr_q.size() - wr_base), 32'd4);
        check_wr(0, 19'h05555, 8'hAA);
        check_wr(1, 19'h02AAA, 8'h55);
        check_wr(2, 19'h05555, 8'hA0);
        check_wr(3, 19'h01234, 8'h5A);
        check("prog_nrd", 32'(rd_cnt - rd_base), 32'd6);
        status_read(v);
        check("prog_st_read", 32'(v), 32'h41);
        check("prog_st_clr", 32'(reg_rdata), 32'h01);

        // Sector erase at 0x30000, grant withheld before the third write
        reg_write(3'd0, 8'h00);
        reg_write(3'd1, 8'h00);
        reg_write(3'd2, 8'h03);
        start_op(2, 1'b0, 8'hFF);
        reg_write(3'd4, 8'h02);
        wait_writes("se_wait2", 2, 1'b0, 100);
        flash_gnt = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clock);
            #1;
            check($sformatf("se_nowe%0d", i), 32'(f_we), 32'd0);
        end
        check("se_req_held", 32'(flash_req), 32'd1);
        check("se_wr_held", 32'(wr_addr_q.size() - wr_base), 32'd2);
        flash_gnt = 1'b1;
        wait_done("se_done_wait", 400);
        check("se_status", 32'(reg_rdata), 32'h42);
        check("se_nwr", 32'(wr_addr_q.size() - wr_base), 32'd6);
        check_wr(0, 19'h05555, 8'hAA);
        check_wr(1, 19'h02AAA, 8'h55);
        check_wr(2, 19'h05555, 8'h80);
        check_wr(3, 19'h05555, 8'hAA);
        check_wr(4, 19'h02AAA, 8'h55);
        check_wr(5, 19'h30000, 8'h30);
        check("se_nrd", 32'(rd_cnt - rd_base), 32'd4);
        check("se_we_nognt", 32'(we_nognt), 32'd0);
        check("se_bad_pulse", 32'(bad_pulse), 32'd0);
        check("se_we_no_ce", 32'(we_bad), 32'd0);
        status_read(v);

        // DQ6 toggles forever: timeout after 15 polls
        reg_write(3'd2, 8'h00);
        reg_write(3'd1, 8'h12);
        reg_write(3'd0, 8'h34);
        start_op(0, 1'b1, 8'h00);
        reg_write(3'd4, 8'h01);
        wait_done("tmo_done_wait", 600);
        check("tmo_status", 32'(reg_rdata), 32'h61);
        check("tmo_req", 32'(flash_req), 32'd0);
        check("tmo_nrd", 32'(rd_cnt - rd_base), 32'd15);
        status_read(v);

        // Program with wrong final readback
        start_op(4, 1'b0, 8'h5B);
        reg_write(3'd4, 8'h01);
        wait_done("vf_done_wait", 400);
        check("vf_status", 32'(reg_rdata), 32'h51);
        status_read(v);
        check("vf_st_clr", 32'(reg_rdata), 32'h01);

        // CMD and DATA writes while busy are ignored; bad code in IDLE
        start_op(2, 1'b0, 8'h5A);
        reg_write(3'd4, 8'h01);
        repeat (3) @(negedge clock);
        reg_write(3'd4, 8'h01);
        check("ign_busy", 32'(reg_rdata), 32'h89);
        reg_write(3'd3, 8'h00);
        wait_done("ign_done_wait", 400);
        check("ign_status", 32'(reg_rdata), 32'h49);
        check("ign_nwr", 32'(wr_addr_q.size() - wr_base), 32'd4);
        reg_peek(3'd3, v); check("ign_data_kept", 32'(v), 32'h5A);
        status_read(v);
        reg_write(3'd4, 8'h07);
        check("bad_cmd_status", 32'(reg_rdata), 32'h09);
        repeat (3) @(negedge clock);
        #1;
        check("bad_cmd_idle", 32'(reg_rdata), 32'h09);
        check("bad_cmd_req", 32'(flash_req), 32'd0);
        status_read(v);

        // Reset during W_PULSE of step 2
        start_op(4, 1'b0, 8'h5A);
        reg_write(3'd4, 8'h01);
        wait_writes("rst_wait_pulse", 2, 1'b1, 100);
        reset = 1'b1;
        @(negedge clock);
        #1;
        check("mid_rst_strobes", 32'({f_ce, f_we, f_oe, f_drive}), 32'd0);
        check("mid_rst_req", 32'(flash_req), 32'd0);
        check("mid_rst_status", 32'(reg_rdata), 32'h00);
        reset = 1'b0;
        repeat (3) @(negedge clock);
        #1;
        check("post_rst_idle", 32'({flash_req, f_ce, reg_rdata}), 32'h000);
        reg_peek(3'd3, v); check("post_rst_data", 32'(v), 32'hFF);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
